median_window_stream: RTL

- Streaming front end that converts a serial sample stream into 3-sample sliding windows for the downstream 3-input median finder.
- Each accepted sample produces exactly one window output, centred on that sample.
- Frame edges are handled by replicating the edge sample.
- Valid/ready handshake on both sides; registered outputs.

---
 rtl/median_window_stream.sv | 129 ++++++++++++
 1 files changed

// File: rtl/median_window_stream.sv
// Streaming 3-sample window generator for a median filter; edge samples replicate at frame edges.
// Optional combinational median output is enabled by MEDIAN_WINDOW_STREAM_MEDIAN_EN.
module median_window_stream #(
    parameter int unsigned DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [DATA_W-1:0] win0,
    output logic [DATA_W-1:0] win1,
    output logic [DATA_W-1:0] win2,
    output logic              win_last
`ifdef MEDIAN_WINDOW_STREAM_MEDIAN_EN
    ,
    output logic [DATA_W-1:0] median
`endif
);

    typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [DATA_W-1:0] cur_q, cur_d;
    logic [DATA_W-1:0] win0_q, win0_d;
    logic [DATA_W-1:0] win1_q, win1_d;
    logic [DATA_W-1:0] win2_q, win2_d;
    logic              win_last_q, win_last_d;
    logic              win_valid_q, win_valid_d;
    logic              free;
    logic              in_xfer;

    // Output slot can take a new window if empty or being drained this cycle.
    assign free     = !win_valid_q || win_ready;
    assign in_ready = (state_q != StFlush) && free;
    assign in_xfer  = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        win0_d      = win0_q;
        win1_d      = win1_q;
        win2_d      = win2_q;
        win_last_d  = win_last_q;
        win_valid_d = win_valid_q;
        if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (in_xfer) begin
                    prev_d  = in_data;
                    cur_d   = in_data;
                    state_d = in_last ? StFlush : StStream;
                end
            end
            StStream: begin
                if (in_xfer) begin
                    win0_d      = prev_q;
                    win1_d      = cur_q;
                    win2_d      = in_data;
                    win_last_d  = 1'b0;
                    win_valid_d = 1'b1;
                    prev_d      = cur_q;
                    cur_d       = in_data;
                    state_d     = in_last ? StFlush : StStream;
                end
            end
            StFlush: begin
                if (free) begin
                    win0_d      = prev_q;
                    win1_d      = cur_q;
                    win2_d      = cur_q;
                    win_last_d  = 1'b1;
                    win_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            prev_q      <= '0;
            cur_q       <= '0;
            win0_q      <= '0;
            win1_q      <= '0;
            win2_q      <= '0;
            win_last_q  <= 1'b0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            win0_q      <= win0_d;
            win1_q      <= win1_d;
            win2_q      <= win2_d;
            win_last_q  <= win_last_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign win0      = win0_q;
    assign win1      = win1_q;
    assign win2      = win2_q;
    assign win_last  = win_last_q;
    assign win_valid = win_valid_q;

`ifdef MEDIAN_WINDOW_STREAM_MEDIAN_EN
    logic [DATA_W-1:0] lo_ab, hi_ab, lo_hc;

    // median = max(min(a,b), min(max(a,b),c))
    always_comb begin
        lo_ab  = (win0_q < win1_q) ? win0_q : win1_q;
        hi_ab  = (win0_q < win1_q) ? win1_q : win0_q;
        lo_hc  = (hi_ab < win2_q) ? hi_ab : win2_q;
        median = (lo_ab > lo_hc) ? lo_ab : lo_hc;
    end
`endif

endmodule
